// File: rtl/subpel_pkg.sv
// Shared types and index/arithmetic helpers for the sequential 1x1 conv + pixel-shuffle engine.
package subpel_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB, S_DONE} state_e;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } sat_res_t;

    function automatic int acc_width(input int dw, input int nic);
        return 2 * dw + $clog2(nic) + 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int input_index(input int ic, input int y, input int x,
                                       input int h, input int w);
        return (ic * h + y) * w + x;
    endfunction

    function automatic int kernel_ch(input int c, input int dy, input int dx, input int r);
        return c * r * r + dy * r + dx;
    endfunction

    function automatic int weight_index(input int k, input int ic, input int nic);
        return k * nic + ic;
    endfunction

    function automatic int shuffle_index(input int c, input int y, input int x, input int dy,
                                         input int dx, input int h, input int w, input int r);
        return (c * h * r + y * r + dy) * (w * r) + x * r + dx;
    endfunction

    // Round half-up at the binary point, arithmetic shift down, then clamp to dw bits.
    function automatic sat_res_t sat_round(input logic signed [63:0] acc, input int frac,
                                           input int dw);
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        v = acc;
        if (frac > 0) v = v + (64'sd1 <<< (frac - 1));
        v = v >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        r.sat = 1'b0;
        r.val = v;
        if (v > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (v < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/subpel_mac_unit.sv
// Signed multiply-accumulate with bias preload, and combinational round/saturate/ReLU of the sum.
module subpel_mac_unit import subpel_pkg::*; #(
    parameter int DATA_WIDTH  = 8,
    parameter int IN_CHANNELS = 1,
    parameter int FRAC_BITS   = 0
) (
    input  logic                         clk,
    input  logic                         load_bias_i,
    input  logic                         acc_i,
    input  logic                         relu_i,
    input  logic signed [DATA_WIDTH-1:0] bias_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         sat_o
);

    localparam int ACC_W = acc_width(DATA_WIDTH, IN_CHANNELS);

    logic signed [ACC_W-1:0]        acc_q;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        prod_ext;
    logic signed [ACC_W-1:0]        bias_ext;
    sat_res_t                       rnd;

    assign prod     = a_i * b_i;
    assign prod_ext = {{(ACC_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    // Bias is in the operand Q format; products carry twice the fraction bits.
    assign bias_ext = {{(ACC_W-DATA_WIDTH){bias_i[DATA_WIDTH-1]}}, bias_i} <<< FRAC_BITS;

    always_ff @(posedge clk) begin
        if (load_bias_i) begin
            acc_q <= bias_ext;
        end else if (acc_i) begin
            acc_q <= acc_q + prod_ext;
        end
    end

    assign rnd    = sat_round({{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q}, FRAC_BITS, DATA_WIDTH);
    assign sat_o  = rnd.sat;
    assign data_o = (relu_i && rnd.val[63]) ? '0 : rnd.val[DATA_WIDTH-1:0];

endmodule

// File: rtl/subpel_conv1x1_seq.sv
// Sequential 1x1 convolution with pixel-shuffle scatter: one MAC per cycle, one element written per WB.
module subpel_conv1x1_seq import subpel_pkg::*; #(
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 1,
    parameter int UPSCALE      = 2,
    parameter int H            = 2,
    parameter int W            = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int FRAC_BITS    = 0,
    localparam int NK          = OUT_CHANNELS * UPSCALE * UPSCALE,
    localparam int TOTAL       = OUT_CHANNELS * H * UPSCALE * W * UPSCALE,
    localparam int OIW         = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    relu_en,
    input  logic [IN_CHANNELS*H*W*DATA_WIDTH-1:0]   input_tensor_flat,
    input  logic [NK*IN_CHANNELS*DATA_WIDTH-1:0]    weights_flat,
    input  logic [NK*DATA_WIDTH-1:0]                bias_flat,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    sat_flag,
    output logic                                    out_valid,
    output logic [OIW-1:0]                          out_index,
    output logic [DATA_WIDTH-1:0]                   out_data,
    output logic [TOTAL*DATA_WIDTH-1:0]             output_tensor_flat
);

    localparam int R   = UPSCALE;
    localparam int ICW = cnt_width(IN_CHANNELS);
    localparam int CW  = cnt_width(OUT_CHANNELS);
    localparam int YW  = cnt_width(H);
    localparam int XW  = cnt_width(W);
    localparam int RW  = cnt_width(R);

    state_e                         state_q, state_d;
    logic [ICW-1:0]                 ic_q, ic_d;
    logic [CW-1:0]                  c_q, c_d;
    logic [YW-1:0]                  y_q, y_d;
    logic [XW-1:0]                  x_q, x_d;
    logic [RW-1:0]                  dy_q, dy_d, dx_q, dx_d;
    logic                           relu_q, sat_q;
    logic [TOTAL*DATA_WIDTH-1:0]    tensor_q;
    logic                           load_bias, acc_en, wr_en, last_elem;
    logic signed [DATA_WIDTH-1:0]   mac_a, mac_b, mac_bias, mac_data;
    logic                           mac_sat;
    int                             in_idx, wt_idx, b_idx, o_idx;

    // Bias for the preload comes from the next-element counters so WB can chain straight into RUN.
    always_comb begin
        in_idx = input_index(int'(ic_q), int'(y_q), int'(x_q), H, W);
        wt_idx = weight_index(kernel_ch(int'(c_q), int'(dy_q), int'(dx_q), R), int'(ic_q),
                              IN_CHANNELS);
        b_idx  = kernel_ch(int'(c_d), int'(dy_d), int'(dx_d), R);
        o_idx  = shuffle_index(int'(c_q), int'(y_q), int'(x_q), int'(dy_q), int'(dx_q), H, W, R);
    end

    assign mac_a     = input_tensor_flat[in_idx*DATA_WIDTH +: DATA_WIDTH];
    assign mac_b     = weights_flat[wt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign mac_bias  = bias_flat[b_idx*DATA_WIDTH +: DATA_WIDTH];
    assign last_elem = (c_q == CW'(OUT_CHANNELS-1)) && (y_q == YW'(H-1)) && (x_q == XW'(W-1))
                    && (dy_q == RW'(R-1)) && (dx_q == RW'(R-1));

    always_comb begin
        state_d   = state_q;
        ic_d      = ic_q;
        c_d       = c_q;
        y_d       = y_q;
        x_d       = x_q;
        dy_d      = dy_q;
        dx_d      = dx_q;
        load_bias = 1'b0;
        acc_en    = 1'b0;
        wr_en     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    load_bias = 1'b1;
                    ic_d      = '0;
                    c_d       = '0;
                    y_d       = '0;
                    x_d       = '0;
                    dy_d      = '0;
                    dx_d      = '0;
                end
            end
            S_RUN: begin
                acc_en = 1'b1;
                if (ic_q == ICW'(IN_CHANNELS-1)) begin
                    ic_d    = '0;
                    state_d = S_WB;
                end else begin
                    ic_d = ic_q + ICW'(1);
                end
            end
            S_WB: begin
                wr_en = 1'b1;
                if (last_elem) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_RUN;
                    load_bias = 1'b1;
                    dx_d      = dx_q + RW'(1);
                    if (dx_q == RW'(R-1)) begin
                        dx_d = '0;
                        dy_d = dy_q + RW'(1);
                        if (dy_q == RW'(R-1)) begin
                            dy_d = '0;
                            x_d  = x_q + XW'(1);
                            if (x_q == XW'(W-1)) begin
                                x_d = '0;
                                y_d = y_q + YW'(1);
                                if (y_q == YW'(H-1)) begin
                                    y_d = '0;
                                    c_d = c_q + CW'(1);
                                end
                            end
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ic_q     <= '0;
            c_q      <= '0;
            y_q      <= '0;
            x_q      <= '0;
            dy_q     <= '0;
            dx_q     <= '0;
            relu_q   <= 1'b0;
            sat_q    <= 1'b0;
            tensor_q <= '0;
        end else begin
            state_q <= state_d;
            ic_q    <= ic_d;
            c_q     <= c_d;
            y_q     <= y_d;
            x_q     <= x_d;
            dy_q    <= dy_d;
            dx_q    <= dx_d;
            if (state_q == S_IDLE && start) begin
                relu_q <= relu_en;
                sat_q  <= 1'b0;
            end
            if (wr_en) begin
                tensor_q[o_idx*DATA_WIDTH +: DATA_WIDTH] <= mac_data;
                if (mac_sat) sat_q <= 1'b1;
            end
        end
    end

    subpel_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .IN_CHANNELS(IN_CHANNELS),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .clk        (clk),
        .load_bias_i(load_bias),
        .acc_i      (acc_en),
        .relu_i     (relu_q),
        .bias_i     (mac_bias),
        .a_i        (mac_a),
        .b_i        (mac_b),
        .data_o     (mac_data),
        .sat_o      (mac_sat)
    );

    assign busy               = (state_q == S_RUN) || (state_q == S_WB);
    assign done               = (state_q == S_DONE);
    assign sat_flag           = sat_q;
    assign out_valid          = wr_en;
    assign out_index          = wr_en ? OIW'(o_idx) : '0;
    assign out_data           = wr_en ? mac_data : '0;
    assign output_tensor_flat = tensor_q;

endmodule

// File: tb/tb_subpel_conv1x1_seq.sv
// Scoreboard bench: random and directed tensors against a per-output-pixel reference model.
module tb_subpel_conv1x1_seq;

    localparam int IC      = 3;
    localparam int C       = 2;
    localparam int R       = 2;
    localparam int H       = 2;
    localparam int W       = 3;
    localparam int DW      = 8;
    localparam int F       = 4;
    localparam int K       = C * R * R;
    localparam int TOT     = C * H * R * W * R;
    localparam int OIW     = $clog2(TOT);
    localparam int RUN_CYC = K * H * W * (IC + 1);
    localparam int MAXV    = 2 ** (DW - 1) - 1;
    localparam int MINV    = -(2 ** (DW - 1));

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  relu_en = 1'b0;
    logic [IC*H*W*DW-1:0]  in_flat = '0;
    logic [K*IC*DW-1:0]    w_flat = '0;
    logic [K*DW-1:0]       b_flat = '0;
    logic                  busy, done, sat_flag, out_valid;
    logic [OIW-1:0]        out_index;
    logic [DW-1:0]         out_data;
    logic [TOT*DW-1:0]     out_t;

    int in_v [IC][H][W];
    int w_v  [K][IC];
    int b_v  [K];
    int exp_t[TOT];
    bit exp_sat;

    typedef struct {
        int idx;
        int val;
    } exp_s;
    exp_s sb[$];
    exp_s mon_e;

    int checks   = 0;
    int failures = 0;

    subpel_conv1x1_seq #(
        .IN_CHANNELS (IC),
        .OUT_CHANNELS(C),
        .UPSCALE     (R),
        .H           (H),
        .W           (W),
        .DATA_WIDTH  (DW),
        .FRAC_BITS   (F)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .relu_en           (relu_en),
        .input_tensor_flat (in_flat),
        .weights_flat      (w_flat),
        .bias_flat         (b_flat),
        .busy              (busy),
        .done              (done),
        .sat_flag          (sat_flag),
        .out_valid         (out_valid),
        .out_index         (out_index),
        .out_data          (out_data),
        .output_tensor_flat(out_t)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stray_output: index %0d data %0d with nothing expected",
                         out_index, $signed(out_data));
            end else begin
                mon_e = sb.pop_front();
                check("out_index", int'(out_index), mon_e.idx);
                check("out_data", int'($signed(out_data)), mon_e.val);
            end
        end
    end

    task automatic fill_random(input int m);
        for (int ic = 0; ic < IC; ic++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    in_v[ic][y][x] = int'($urandom_range(0, 2 * m - 1)) - m;
        for (int k = 0; k < K; k++) begin
            b_v[k] = int'($urandom_range(0, 2 * m - 1)) - m;
            for (int ic = 0; ic < IC; ic++) w_v[k][ic] = int'($urandom_range(0, 2 * m - 1)) - m;
        end
    endtask

    task automatic fill_const(input int iv, input int wv0, input int wvr, input int bv);
        for (int ic = 0; ic < IC; ic++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) in_v[ic][y][x] = iv;
        for (int k = 0; k < K; k++) begin
            b_v[k] = bv;
            for (int ic = 0; ic < IC; ic++) w_v[k][ic] = (ic == 0) ? wv0 : wvr;
        end
    endtask

    task automatic pack();
        for (int ic = 0; ic < IC; ic++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    in_flat[((ic * H + y) * W + x) * DW +: DW] = DW'(in_v[ic][y][x]);
        for (int k = 0; k < K; k++) begin
            b_flat[k * DW +: DW] = DW'(b_v[k]);
            for (int ic = 0; ic < IC; ic++) w_flat[(k * IC + ic) * DW +: DW] = DW'(w_v[k][ic]);
        end
    endtask

    // Reference: real-valued dot product in Q-format, round half-up via floor division, clamp, ReLU.
    function automatic void model(input bit relu);
        longint acc, v;
        int     k, idx;
        sb.delete();
        exp_sat = 1'b0;
        for (int c = 0; c < C; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    for (int dy = 0; dy < R; dy++)
                        for (int dx = 0; dx < R; dx++) begin
                            k   = c * R * R + dy * R + dx;
                            acc = longint'(b_v[k]) * (2 ** F);
                            for (int ic = 0; ic < IC; ic++)
                                acc += longint'(in_v[ic][y][x]) * longint'(w_v[k][ic]);
                            acc += 2 ** (F - 1);
                            if (acc >= 0) v = acc / (2 ** F);
                            else v = -((-acc + (2 ** F) - 1) / (2 ** F));
                            if (v > MAXV) begin
                                v = MAXV;
                                exp_sat = 1'b1;
                            end else if (v < MINV) begin
                                v = MINV;
                                exp_sat = 1'b1;
                            end
                            if (relu && v < 0) v = 0;
                            idx        = ((c * H * R) + y * R + dy) * (W * R) + x * R + dx;
                            exp_t[idx] = int'(v);
                            sb.push_back('{idx, int'(v)});
                        end
    endfunction

    task automatic do_run(input bit relu, input string tag);
        int cyc, busy_cnt, done_at;
        pack();
        model(relu);
        @(negedge clk);
        relu_en = relu;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        relu_en = ~relu;
        cyc      = 0;
        busy_cnt = 0;
        done_at  = -1;
        while (done_at < 0 && cyc < RUN_CYC + 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 20) start = 1'b1;
            if (cyc == 21) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_at = cyc;
        end
        check({tag, "_done_cycle"}, done_at, RUN_CYC + 1);
        check({tag, "_busy_cycles"}, busy_cnt, RUN_CYC);
        check({tag, "_sat_flag"}, int'(sat_flag), int'(exp_sat));
        check({tag, "_pending"}, sb.size(), 0);
        for (int i = 0; i < TOT; i++)
            check({tag, "_tensor"}, int'($signed(out_t[i*DW +: DW])), exp_t[i]);
        start = 1'b1;
        @(negedge clk);
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_idle_done"}, int'(done), 0);
        start = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_sat_flag"}, int'(sat_flag), 0);
        check({tag, "_out_index"}, int'(out_index), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_tensor_nonzero"}, (out_t == '0) ? 0 : 1, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        fill_const(8'h18, 8'h18, 0, 0);
        do_run(1'b0, "q4_mul");
        check("q4_mul_value", int'($signed(out_t[0 +: DW])), 8'h24);
        fill_const(8'h18, 8'h18, 0, 8'h08);
        do_run(1'b0, "q4_bias");
        check("q4_bias_value", int'($signed(out_t[(TOT-1)*DW +: DW])), 8'h2C);

        for (int ic = 0; ic < IC; ic++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) in_v[ic][y][x] = ic + 1;
        for (int k = 0; k < K; k++) begin
            b_v[k]    = 5;
            w_v[k][0] = 1;
            w_v[k][1] = 1;
            w_v[k][2] = -1;
        end
        do_run(1'b0, "multi_ic");
        check("multi_ic_value", int'($signed(out_t[7*DW +: DW])), 5);

        fill_const(100, 100, 100, 0);
        do_run(1'b0, "sat_pos");
        check("sat_pos_value", int'($signed(out_t[0 +: DW])), 127);
        fill_const(100, -100, -100, 0);
        do_run(1'b0, "sat_neg");
        check("sat_neg_value", int'($signed(out_t[0 +: DW])), -128);
        do_run(1'b1, "sat_relu");
        check("sat_relu_value", int'($signed(out_t[0 +: DW])), 0);

        for (int n = 0; n < 6; n++) begin
            fill_random((n < 3) ? 128 : 16);
            do_run(n[0], (n < 3) ? "rand_full" : "rand_small");
        end

        fill_random(128);
        pack();
        model(1'b0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        check_cleared("midrun_rst");
        rst = 1'b0;

        fill_random(64);
        do_run(1'b1, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
